// File: rtl/matmul_host_driver.sv
// Host-side byte-stream driver for a 2x2 matrix multiplier with 2-bit operand fields.
// It collects A and B, range-checks them, drives the multiplier, then returns the result lo byte and then the hi byte.
module matmul_host_driver #(
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] mm_a,
    output logic [7:0] mm_b,
    output logic       mm_ena,
    input  logic [7:0] mm_res_lo,
    input  logic [7:0] mm_res_hi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       err,
    output logic [7:0] txn_count
);

    localparam int unsigned   CW        = $clog2(LATENCY + 1) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(LATENCY);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CHECK,
        DRIVE,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [7:0]    r_mm_a;
    logic [7:0]    r_mm_b;
    logic [7:0]    r_res_lo;
    logic [7:0]    r_res_hi;
    logic [7:0]    r_txn;
    logic [CW-1:0] r_wait;
    logic          w_range_err;
    logic          w_wait_done;

    // A field value of 3 is outside the operand range the multiplier is fed with.
    function automatic logic has_field3(input logic [7:0] x);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (x[2*i +: 2] == 2'b11) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_range_err = has_field3(r_a) | has_field3(r_b);
    assign w_wait_done = (r_wait == LAST_WAIT);

    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;
    assign txn_count = r_txn;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mm_ena    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        err       = 1'b0;
        case (r_state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                err    = w_range_err;
                w_next = w_range_err ? LOAD_A : DRIVE;
            end
            DRIVE: begin
                mm_ena = 1'b1;
                if (w_wait_done) begin
                    w_next = SEND_LO;
                end
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_data  = r_res_lo;
                if (out_ready) begin
                    w_next = SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_data  = r_res_hi;
                if (out_ready) begin
                    w_next = LOAD_A;
                end
            end
            default: w_next = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mm_a   <= '0;
            r_mm_b   <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_txn    <= '0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                LOAD_A: if (in_valid) r_a <= in_data;
                LOAD_B: if (in_valid) r_b <= in_data;
                CHECK: begin
                    if (!w_range_err) begin
                        r_mm_a <= r_a;
                        r_mm_b <= r_b;
                        r_wait <= '0;
                    end
                end
                DRIVE: begin
                    // Results are sampled on the final enabled edge, after LATENCY pipeline stages have filled.
                    if (w_wait_done) begin
                        r_res_lo <= mm_res_lo;
                        r_res_hi <= mm_res_hi;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                SEND_HI: if (out_ready) r_txn <= r_txn + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_host_driver.sv
// Directed bench for matmul_host_driver: a pipelined multiplier model feeds the result pins,
// and every expected byte is a hand-computed constant.
module tb_matmul_host_driver;

    localparam int unsigned LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] mm_a;
    logic [7:0] mm_b;
    logic       mm_ena;
    logic [7:0] mm_res_lo;
    logic [7:0] mm_res_hi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       err;
    logic [7:0] txn_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_host_driver #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_ena    (mm_ena),
        .mm_res_lo (mm_res_lo),
        .mm_res_hi (mm_res_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .txn_count (txn_count)
    );

    // Multiplier stand-in: C = A x B, 4-bit result fields, LAT register stages.
    function automatic logic [15:0] mm_model(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] a11, a12, a21, a22, b11, b12, b21, b22;
        logic [3:0] r11, r12, r21, r22;
        a11 = {2'b00, a[1:0]}; a12 = {2'b00, a[3:2]};
        a21 = {2'b00, a[5:4]}; a22 = {2'b00, a[7:6]};
        b11 = {2'b00, b[1:0]}; b12 = {2'b00, b[3:2]};
        b21 = {2'b00, b[5:4]}; b22 = {2'b00, b[7:6]};
        r11 = a11 * b11 + a12 * b21;
        r12 = a11 * b12 + a12 * b22;
        r21 = a21 * b11 + a22 * b21;
        r22 = a21 * b12 + a22 * b22;
        return {r22, r21, r12, r11};
    endfunction

    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mm_model(mm_a, mm_b);
        for (int unsigned k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign mm_res_lo = pipe[LAT-1][7:0];
    assign mm_res_hi = pipe[LAT-1][15:8];

    int unsigned got_n   = 0;
    int unsigned ena_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned ov_cnt  = 0;
    logic [7:0]  got_mem [1024];

    always @(negedge clk) begin
        if (mm_ena)    ena_cnt <= ena_cnt + 1;
        if (err)       err_cnt <= err_cnt + 1;
        if (out_valid) ov_cnt  <= ov_cnt + 1;
        if (out_valid && out_ready) begin
            got_mem[got_n[9:0]] <= out_data;
            got_n               <= got_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic done;
        done     = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("send_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_bytes(input int unsigned n, input int unsigned limit);
        for (int unsigned i = 0; i < limit && got_n < n; i++) begin
            @(negedge clk);
        end
        tick(1);
        chk("bytes_arrived", {31'd0, (got_n >= n)}, 32'd1);
    endtask

    task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] lo, input logic [7:0] hi);
        int unsigned base;
        int unsigned e0;
        base = got_n;
        e0   = ena_cnt;
        send_byte(a);
        send_byte(b);
        wait_bytes(base + 2, 50);
        chk({tag, "_lo"}, got_mem[base[9:0]], lo);
        chk({tag, "_hi"}, got_mem[(base + 1) & 1023], hi);
        tick(2);
        chk({tag, "_ena_cycles"}, ena_cnt - e0, LAT + 1);
    endtask

    task automatic err_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_txn, input logic [7:0] exp_mma);
        int unsigned e0, r0, v0;
        e0 = err_cnt;
        r0 = ena_cnt;
        v0 = ov_cnt;
        send_byte(a);
        send_byte(b);
        tick(6);
        chk({tag, "_err_cycles"}, err_cnt - e0, 1);
        chk({tag, "_ena_cycles"}, ena_cnt - r0, 0);
        chk({tag, "_out_valid"},  ov_cnt - v0, 0);
        chk({tag, "_txn"},        txn_count, exp_txn);
        chk({tag, "_mm_a_kept"},  mm_a, exp_mma);
        chk({tag, "_in_ready"},   in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [7:0]  vlo [4];
        logic [7:0]  vhi [4];
        int unsigned base;
        int unsigned tries;

        va[0] = 8'h49; vb[0] = 8'h16; vlo[0] = 8'h14; vhi[0] = 8'h01;
        va[1] = 8'hAA; vb[1] = 8'hAA; vlo[1] = 8'h88; vhi[1] = 8'h88;
        va[2] = 8'h41; vb[2] = 8'h26; vlo[2] = 8'h12; vhi[2] = 8'h02;
        va[3] = 8'h49; vb[3] = 8'h19; vlo[3] = 8'h23; vhi[3] = 8'h01;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  8'h00);
        chk("rst_mm_a",      mm_a,      8'h00);
        chk("rst_mm_b",      mm_b,      8'h00);
        chk("rst_mm_ena",    mm_ena,    0);
        chk("rst_err",       err,       0);
        chk("rst_txn",       txn_count, 8'h00);
        tick(1);

        txn("t1", 8'h49, 8'h16, 8'h14, 8'h01);
        chk("t1_txn",  txn_count, 8'h01);
        chk("t1_mm_a", mm_a, 8'h49);
        chk("t1_mm_b", mm_b, 8'h16);
        chk("t1_mm_ena_idle", mm_ena, 0);

        txn("t2", 8'hAA, 8'hAA, 8'h88, 8'h88);
        chk("t2_txn", txn_count, 8'h02);

        // Identity A: result fields equal the B fields.
        txn("t3", 8'h41, 8'h26, 8'h12, 8'h02);
        chk("t3_txn", txn_count, 8'h03);

        err_txn("e1", 8'h03, 8'h00, 8'h03, 8'h41);
        err_txn("e2", 8'h41, 8'h9C, 8'h03, 8'h41);
        txn("t4", 8'h49, 8'h16, 8'h14, 8'h01);
        chk("t4_txn", txn_count, 8'h04);

        // Back-pressure on SEND_LO with a pending host byte that must wait for LOAD_A.
        base      = got_n;
        out_ready = 1'b0;
        send_byte(8'h49);
        send_byte(8'h19);
        in_data  = 8'h55;
        in_valid = 1'b1;
        tries    = 0;
        @(negedge clk);
        while (!out_valid && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        chk("bp_reached_send", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data",  out_data,  8'h23);
            chk("bp_in_ready",  in_ready,  0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_byte(8'h55);
        send_byte(8'h55);
        wait_bytes(base + 4, 60);
        chk("bp_b0", got_mem[base[9:0]], 8'h23);
        chk("bp_b1", got_mem[(base + 1) & 1023], 8'h01);
        chk("bp_b2", got_mem[(base + 2) & 1023], 8'h22);
        chk("bp_b3", got_mem[(base + 3) & 1023], 8'h22);
        chk("bp_txn", txn_count, 8'h06);

        // Reset while the multiplier is being driven.
        send_byte(8'hAA);
        send_byte(8'hAA);
        tries = 0;
        @(negedge clk);
        while (!mm_ena && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        chk("mid_in_drive", mm_ena, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_mm_ena",    mm_ena,    0);
        chk("mid_rst_mm_a",      mm_a,      8'h00);
        chk("mid_rst_txn",       txn_count, 8'h00);
        chk("mid_rst_in_ready",  in_ready,  1);
        base = got_n;
        tick(12);
        chk("mid_rst_no_stale", got_n - base, 0);

        // 255 back-to-back transactions, then the wrapping 256th.
        base = got_n;
        for (int i = 0; i < 255; i++) begin
            send_byte(va[i % 4]);
            send_byte(vb[i % 4]);
        end
        wait_bytes(base + 510, 100);
        for (int i = 0; i < 255; i++) begin
            chk("b2b_lo", got_mem[(base + 2 * i) & 1023],     vlo[i % 4]);
            chk("b2b_hi", got_mem[(base + 2 * i + 1) & 1023], vhi[i % 4]);
        end
        chk("b2b_txn_255", txn_count, 8'hFF);
        txn("t256", 8'hAA, 8'hAA, 8'h88, 8'h88);
        chk("b2b_txn_wrap", txn_count, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
